local_net_iface: RTL

//  Network interface between a processing element (PE) and a router's local (L) port.
//  Tx: accepts PE flits over valid/ready and forms 16-bit flits {payload[7:0], dest[7:0]}.

---
 rtl/local_net_iface.sv | 126 ++++++++++++
 1 files changed

// File: rtl/local_net_iface.sv
// Local-port network interface: PE <-> router L port.
// Tx side injects {payload,dest} flits under credit flow control; Rx side buffers
// router flits for the PE and returns one credit per consumed flit.
module local_net_iface #(
  parameter int unsigned XCOORD     = 4'b1111,
  parameter int unsigned YCOORD     = 4'b1111,
  parameter logic [7:0]  LOCAL_ADDR = 8'h00,
  parameter int unsigned TX_CREDITS = 4,
  parameter int unsigned RX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pe_tx_data,
  input  logic [7:0]  pe_tx_dest,
  input  logic        pe_tx_valid,
  output logic        pe_tx_ready,
  output logic [15:0] L_data_o,
  output logic        L_enable_o,
  input  logic        L_credit_i,
  input  logic [15:0] L_data_i,
  input  logic        L_enable_i,
  output logic        L_credit_o,
  output logic [15:0] pe_rx_data,
  output logic        pe_rx_valid,
  input  logic        pe_rx_ready,
  output logic [7:0]  misroute_cnt,
  output logic        rx_overflow
);

  localparam int unsigned CW = $clog2(TX_CREDITS + 1);
  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(TX_CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  if (TX_CREDITS < 1 || TX_CREDITS > 15 || RX_DEPTH < 2 ||
      (RX_DEPTH & (RX_DEPTH - 1)) != 0 || XCOORD > 15 || YCOORD > 15) begin : g_bad_params
    $error("local_net_iface: illegal parameter set");
  end

  logic            r_rst_q;
  logic [CW-1:0]   r_credits;
  logic [15:0]     r_l_data;
  logic            r_l_enable;
  logic            r_l_credit;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [15:0]     r_mem [RX_DEPTH];
  logic [7:0]      r_misroute;
  logic            r_overflow;

  logic            w_tx_ready;
  logic            w_tx_fire;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_ok;

  // Handshake and FIFO status decode from registered state only.
  always_comb begin
    w_tx_ready = !r_rst_q && (r_credits != '0);
    w_tx_fire  = pe_tx_valid && w_tx_ready;
    w_empty    = (r_wr_ptr == r_rd_ptr);
    w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop      = !w_empty && pe_rx_ready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted.
    w_wr_ok    = L_enable_i && (!w_full || w_pop);
  end

  // Tx path: credit counter and one-cycle injection register.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_credits  <= CRED_MAX;
      r_l_data   <= '0;
      r_l_enable <= 1'b0;
    end else begin
      r_l_enable <= w_tx_fire;
      if (w_tx_fire) r_l_data <= {pe_tx_data, pe_tx_dest};
      if (L_credit_i && !w_tx_fire) begin
        if (r_credits != CRED_MAX) r_credits <= r_credits + CRED_ONE;
      end else if (w_tx_fire && !L_credit_i) begin
        r_credits <= r_credits - CRED_ONE;
      end
    end
  end

  // Rx path: pointers, credit return, misroute counter, sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_l_credit <= 1'b0;
      r_misroute <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_l_credit <= w_pop;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (L_data_i[7:0] != LOCAL_ADDR && r_misroute != '1)
          r_misroute <= r_misroute + 8'd1;
      end
      if (L_enable_i && !w_wr_ok) r_overflow <= 1'b1;
    end
  end

  // Rx storage; contents are only observed through the non-empty head.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= L_data_i;
  end

  a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(L_credit_i && !w_tx_fire && r_credits == CRED_MAX));

  assign pe_tx_ready  = w_tx_ready;
  assign L_data_o     = r_l_data;
  assign L_enable_o   = r_l_enable;
  assign L_credit_o   = r_l_credit;
  assign pe_rx_valid  = !w_empty;
  assign pe_rx_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign misroute_cnt = r_misroute;
  assign rx_overflow  = r_overflow;

endmodule
